// File: rtl/multi_timer_pkg.sv
// Shared constants for the multi-channel Z80 interval timer.
// Control-word bit positions and write-select encodings.
package multi_timer_pkg;

    localparam int CTL_EN      = 0;
    localparam int CTL_PER     = 1;
    localparam int CTL_RESTART = 2;

    localparam logic SEL_RELOAD = 1'b0;
    localparam logic SEL_CTRL   = 1'b1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: down-counter, reload register, EN/PER control
// and a sticky pending flag cleared by acknowledge.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_wr_reload,
    input  logic             i_wr_ctrl,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_ack,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_en,
    output logic             o_pending,
    output logic             o_expire
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_reload;
    logic             r_en;
    logic             r_per;
    logic             r_pending;
    logic             w_expire;
    logic             w_load;

    assign w_expire = i_tick && r_en && (r_cnt == '0);
    assign w_load   = (!r_en && i_wr_data[CTL_EN]) || i_wr_data[CTL_RESTART];

    // A control write takes priority over the tick; r_reload reads the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_reload  <= '0;
            r_en      <= 1'b0;
            r_per     <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            if (i_wr_reload) begin
                r_reload <= i_wr_data;
            end
            if (i_wr_ctrl) begin
                r_en  <= i_wr_data[CTL_EN];
                r_per <= i_wr_data[CTL_PER];
                if (w_load) begin
                    r_cnt <= r_reload;
                end
            end else if (i_tick && r_en) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - WIDTH'(1);
                end else if (r_per) begin
                    r_cnt <= r_reload;
                end else begin
                    r_en <= 1'b0;
                end
            end
            if (w_expire) begin
                r_pending <= 1'b1;
            end else if (i_ack) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_cnt     = r_cnt;
    assign o_en      = r_en;
    assign o_pending = r_pending;
    assign o_expire  = w_expire;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel programmable interval timer for the Z80 interrupt path:
// shared prescaler, NCH channels, write decode, int_stb and readback.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int WIDTH = 16,
    parameter int PRE_W = 8,
    parameter int CHW   = 2
) (
    input  logic             clk_z80,
    input  logic             rst,
    input  logic [PRE_W-1:0] pre_div,
    input  logic             wr_stb,
    input  logic [CHW-1:0]   wr_ch,
    input  logic             wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [NCH-1:0]   ack,
    input  logic [CHW-1:0]   cnt_sel,
    output logic [WIDTH-1:0] cnt_out,
    output logic [NCH-1:0]   running,
    output logic [NCH-1:0]   irq_pending,
    output logic             int_stb
);

    logic [PRE_W-1:0] r_pre_ctr;
    logic             r_int_stb;
    logic [WIDTH-1:0] r_cnt_out;
    logic             w_tick;
    logic [NCH-1:0]   w_wr_reload;
    logic [NCH-1:0]   w_wr_ctrl;
    logic [NCH-1:0]   w_expire;
    logic [WIDTH-1:0] w_cnt [NCH];
    logic [WIDTH-1:0] w_rd;

    // >= rather than == so a lowered pre_div cannot let the counter run away
    assign w_tick = (r_pre_ctr >= pre_div);

    always_ff @(posedge clk_z80 or posedge rst) begin
        if (rst) begin
            r_pre_ctr <= '0;
        end else if (w_tick) begin
            r_pre_ctr <= '0;
        end else begin
            r_pre_ctr <= r_pre_ctr + PRE_W'(1);
        end
    end

    // Exact index match means out-of-range channels decode to nothing.
    always_comb begin
        w_wr_reload = '0;
        w_wr_ctrl   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (wr_stb && (wr_ch == CHW'(i))) begin
                w_wr_reload[i] = (wr_sel == SEL_RELOAD);
                w_wr_ctrl[i]   = (wr_sel == SEL_CTRL);
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        timer_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk         (clk_z80),
            .rst         (rst),
            .i_tick      (w_tick),
            .i_wr_reload (w_wr_reload[g]),
            .i_wr_ctrl   (w_wr_ctrl[g]),
            .i_wr_data   (wr_data),
            .i_ack       (ack[g]),
            .o_cnt       (w_cnt[g]),
            .o_en        (running[g]),
            .o_pending   (irq_pending[g]),
            .o_expire    (w_expire[g])
        );
    end

    always_comb begin
        w_rd = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cnt_sel == CHW'(i)) begin
                w_rd = w_cnt[i];
            end
        end
    end

    always_ff @(posedge clk_z80 or posedge rst) begin
        if (rst) begin
            r_int_stb <= 1'b0;
            r_cnt_out <= '0;
        end else begin
            r_int_stb <= |w_expire;
            r_cnt_out <= w_rd;
        end
    end

    assign int_stb = r_int_stb;
    assign cnt_out = r_cnt_out;

endmodule
